// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache refill controller.
// On a miss it reads the whole block as 32-bit words, one outstanding read at
// a time, pairs even/odd words into 64-bit beats and strobes them in block order.
module icache_refill_ctrl #(
    parameter int unsigned B = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic        ic_repl_permit_i,
    input  logic        cache_hit_i,
    output logic        rep_ready_o,
    output logic [63:0] rep_word_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned WORDS = B / 4;
    localparam int unsigned K_W   = $clog2(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      base_q;
    logic [K_W-1:0]   k_q;
    logic [31:0]      low_q;
    logic             abort_q;
    logic             start;
    logic             last_word;

    assign start     = (state_q == S_IDLE) && ic_repl_permit_i && !cache_hit_i;
    assign last_word = (k_q == K_W'(WORDS - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (mem_gnt_i)              state_d = S_WAIT;
                else if (!ic_repl_permit_i) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    if (abort_q || !ic_repl_permit_i) state_d = S_IDLE;
                    else if (last_word)               state_d = S_DONE;
                    else                              state_d = S_REQ;
                end
            end
            S_DONE: begin
                if (cache_hit_i || !ic_repl_permit_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory request outputs, driven only while requesting
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if (state_q == S_REQ) begin
            mem_req_o  = 1'b1;
            mem_addr_o = base_q + (32'(k_q) << 2);
        end
    end

    // Datapath: block base, word counter, low-word holding, abort flag, beat output
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            base_q      <= '0;
            k_q         <= '0;
            low_q       <= '0;
            abort_q     <= 1'b0;
            rep_ready_o <= 1'b0;
            rep_word_o  <= '0;
        end else begin
            rep_ready_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= addr_i & ~(32'(B) - 32'd1);
                        k_q     <= '0;
                        low_q   <= '0;
                        abort_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    // A grant coinciding with the permit drop still leaves a read
                    // outstanding; remember to swallow its data.
                    if (mem_gnt_i && !ic_repl_permit_i) abort_q <= 1'b1;
                end
                S_WAIT: begin
                    if (!ic_repl_permit_i) abort_q <= 1'b1;
                    if (mem_rvalid_i) begin
                        if (!last_word) k_q <= k_q + 1'b1;
                        if (!k_q[0]) begin
                            low_q <= mem_rdata_i;
                        end else if (!abort_q && ic_repl_permit_i) begin
                            rep_word_o  <= {mem_rdata_i, low_q};
                            rep_ready_o <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Synthesizable replacement for the simulation-only main-memory model that feeds L1 instruction-cache refills.
- Sits between icache_l1 and the 32-bit backing-memory port.
- On a miss, it fetches the whole cache block as 32-bit word reads, packs pairs of words into 64-bit replacement beats, and delivers the beats in block order.

Parameters:
- B, 64, cache block size in bytes; power of two, at least 8. Must match icache_l1 B.
- WORDS, B/4, derived: 32-bit reads per block. Not overridable.
- BEATS, B/8, derived: 64-bit beats per block. Not overridable.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- addr_i  in  32  fetch PC, i.e. the miss address.
- ic_repl_permit_i  in  1  cache permits a refill; deasserts on flush or redirect.
- cache_hit_i  in  1  cache reports a hit for addr_i.
- rep_ready_o  out  1  one-cycle strobe: rep_word_o holds a valid beat.
- rep_word_o  out  64  beat data: {odd word, even word}, lower address in [31:0].
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  32  word-aligned read address.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

Behaviour:
- Reset (reset_i = 0, async):
  - State goes to IDLE.
  - rep_ready_o, mem_req_o = 0; rep_word_o, mem_addr_o = 0.
  - Word counter and low-word holding register cleared.
- Block base = addr_i with the low log2(B) bits zeroed. It is latched at refill start and held for the whole refill, independent of later addr_i changes.
- One outstanding memory read at a time.
- States:
  - IDLE: if ic_repl_permit_i = 1 and cache_hit_i = 0, latch base, clear word counter k, go to REQ. Otherwise stay.
  - REQ:
    - Drive mem_req_o = 1, mem_addr_o = base + 4k.
    - mem_req_o and mem_addr_o stay stable until mem_gnt_i = 1.
    - On grant, go to WAIT; mem_req_o drops the next cycle unless re-requesting.
  - WAIT:
    - On mem_rvalid_i with k even: store mem_rdata_i as low word.
    - On mem_rvalid_i with k odd: register rep_word_o = {mem_rdata_i, low} and pulse rep_ready_o for exactly one cycle, the cycle after rvalid.
    - k increments on each rvalid. If k was WORDS-1 go to DONE, else go to REQ.
  - DONE:
    - Hold until cache_hit_i = 1 or ic_repl_permit_i = 0, then go to IDLE.
    - Prevents a duplicate refill while the cache installs the line.
- Latency:
  - Zero-wait memory (gnt in the REQ cycle, rvalid the cycle after the grant): 2 cycles per word, so the first rep_ready_o arrives 4 cycles after leaving IDLE.
  - The full 64-byte block takes 32 cycles.
- Abort:
  - If ic_repl_permit_i falls while in REQ before a grant: drop mem_req_o next cycle and go to IDLE.
  - If it falls in WAIT: wait for the outstanding rvalid, discard the data, emit no beat, go to IDLE.
  - Once permit has fallen, no further rep_ready_o strobes are produced for that refill.
- Simultaneous events:
  - Abort and the final rvalid in the same cycle: the abort wins and the beat is not emitted.
  - mem_rvalid_i outside WAIT is ignored.
- Counter is log2(WORDS) bits and does not wrap within a refill; it is cleared on every refill start.
- Mid-operation reset: all state is discarded immediately; no strobe follows deassertion.

Test Plan:
- Basic refill: zero-wait memory returning data = address. Miss at addr_i = 0x0000_1234, B = 64.
  - Requests 0x1200, 0x1204 … 0x123C in order.
  - 8 strobes, first rep_word_o = 0x0000_1204_0000_1200, last = 0x0000_123C_0000_1238.
  - Enters DONE; returns to IDLE once cache_hit_i = 1.
- Grant stall: hold mem_gnt_i low 5 cycles on word 3 -> mem_req_o/mem_addr_o = 0x120C held stable for 6 cycles; beat data is unchanged versus the basic refill.
- Abort: deassert ic_repl_permit_i after the 2nd beat, with a read outstanding -> the pending rvalid is consumed, no 3rd strobe, state is IDLE and mem_req_o = 0.
- Hit suppression: cache_hit_i = 1 with permit = 1 -> mem_req_o never asserts over 20 cycles.
- Async reset mid-refill: pull reset_i low between clock edges during WAIT -> outputs are 0 immediately; after release, a new miss at 0x2000 restarts from word 0 (first mem_addr_o = 0x2000).
- Back-to-back misses: miss 0x1200 completes, hit for 1 cycle, then miss 0x1240 -> second refill issues 0x1240 … 0x127C with 8 strobes and no stale low word (first beat = 0x0000_1244_0000_1240).
